full_err_mon: RTL and testbench
===============================

# full_err_mon

Per-frame error monitor placed directly downstream of the `full_err` stage. It forwards the `stage_1_error` stream unchanged through a 2-entry skid buffer. For each frame (delimited by `fst`) it also accumulates element count, maximum error exponent and the number of over-threshold errors, then emits that summary on a separate valid/ready channel. Training control and debug logic use the summary to watch convergence without touching the datapath.

## Interface
- `CNT_W`, default 16: width of the per-frame counters.
- `clk`  in  1: clock.
- `reset`  in  1: asynchronous, active-high reset.
- `stage_1_error`  in  float_24_8: error value from `full_err`; fields `man` and `exp` come from the types package.
- `stage_1_error_fst`  in  1: first beat of a frame.
- `stage_1_error_vld`  in  1: input beat valid.
- `stage_1_error_rdy`  out  1: input ready; registered, equal to "skid buffer not full".
- `thresh_exp`  in  8: exponent threshold; quasi-static and sampled on each accepted beat.
- `stage_1_delta`  out  float_24_8: forwarded error value.
- `stage_1_delta_fst`  out  1: forwarded `fst`.
- `stage_1_delta_vld`  out  1: output beat valid.
- `stage_1_delta_rdy`  in  1: downstream ready.
- `stat_count`  out  CNT_W: number of beats in the closed frame.
- `stat_max_exp`  out  8: largest `exp` among nonzero beats of the closed frame.
- `stat_over`  out  CNT_W: number of nonzero beats with `exp > thresh_exp`.
- `stat_vld`  out  1: summary valid.
- `stat_rdy`  in  1: summary ready.
- `stat_ovf`  out  1: sticky flag, set when a summary is dropped.

## Operation
- **Transfer rule.** A beat transfers on `vld && rdy` on the same channel and the same cycle, for every channel.
- **Datapath.** The 2-entry FIFO skid buffer forwards `{data, fst}` in order, with no modification and no beat loss.
- **Zero test.** A beat is zero iff `man == 0`. Zero beats count toward `stat_count` only.
- **Accumulators.** `cnt`, `max_exp` and `over`, plus a state bit `in_frame`.
- **State IDLE** (after reset, `in_frame = 0`):
  - Accepted beats with `fst = 0` are forwarded but not counted.
  - An accepted beat with `fst = 1` loads the accumulators with that beat's contribution and moves to FRAME.
- **State FRAME:**
  - An accepted beat with `fst = 0` adds its contribution.
  - An accepted beat with `fst = 1` closes the frame. The old accumulators go to the summary register, the accumulators reload with the new beat's contribution, and the state stays FRAME.
- **Contribution of a beat:**
  - `cnt += 1`.
  - If nonzero: `max_exp = max(max_exp, exp)`.
  - If nonzero and `exp > thresh_exp` (unsigned, strict): `over += 1`.
- **Saturation.** Counters saturate at `2^CNT_W - 1`; they never wrap. `max_exp` is 0 when the frame has no nonzero beats.
- **Summary register.**
  - A close loads the summary and sets `stat_vld` if `stat_vld == 0`, or if `stat_rdy == 1` in the same cycle.
  - Otherwise the new summary is dropped, `stat_ovf` is set, and the pending summary is held unchanged.
- **`stat_ovf`** clears only on reset.
- **Last frame.** There is no end-of-stream flush; the last frame is reported only when the next `fst` arrives.

## Timing
- **Reset values (all outputs 0):**
  - `stage_1_error_rdy = 0` while `reset` is asserted, and 1 in the first cycle after release.
  - `stage_1_delta_vld`, `stage_1_delta`, `stage_1_delta_fst` = 0.
  - `stat_vld`, `stat_count`, `stat_max_exp`, `stat_over`, `stat_ovf` = 0.
  - State is IDLE.
- **Datapath latency.** A beat accepted at cycle t appears on `stage_1_delta` at t+1 at the earliest.
- **Throughput.** One beat per cycle while the downstream is ready.
- **Backpressure.** With `stage_1_delta_rdy` low, the buffer takes at most 2 beats, then `stage_1_error_rdy` drops at the next edge. It does not depend combinationally on `stage_1_delta_rdy`.
- **Full buffer with a pop.** When the buffer is full and a pop occurs in cycle t, `rdy` rises at t+1.
- **Summary latency.** A closing `fst` beat accepted at t gives `stat_vld = 1` at t+1, with stable fields until the `stat_rdy` handshake.
- **Summary handshake.** After `stat_vld && stat_rdy` at t, `stat_vld = 0` at t+1 unless a close also occurred at t.
- **Reset mid-frame.** Asynchronous reset mid-frame discards the buffer contents, the accumulators and any pending summary immediately.

## Structure
- **Types package:**
  - `float_24_8` (existing).
  - New packed struct `err_stat_t {count, max_exp, over}`.
  - Constant `ERR_STAT_CNT_W = 16`.
- **Sub-module `full_err_mon_skid`:** the 2-entry valid/ready skid FIFO, with data type parameterised as 33 bits for `{fst, float_24_8}`.
- **Top level:** accumulator, state bit and summary register.

## Test plan
- **Basic frame.** `thresh_exp = 100`. Frame A = 4 beats with exps {90, 120, 101, 0}, where the last beat has `man = 0`, followed by an `fst` beat. Required: summary `count = 4`, `max_exp = 120`, `over = 2`, `stat_vld` one cycle after the `fst` is accepted, and all 5 beats forwarded in order.
- **Leading beats.** After reset, 3 beats with `fst = 0`, then a frame of 2 beats closed by `fst`. Required: the 3 leading beats are forwarded but not counted, and the summary has `count = 2`.
- **Backpressure.** Hold `stage_1_delta_rdy = 0` while streaming 10 beats. Required: exactly 2 beats are accepted, then `stage_1_error_rdy = 0`. After releasing, all 10 beats arrive in order with none duplicated.
- **Summary overflow.** `stat_rdy = 0`; close two frames, of 3 and 5 beats. Required: the summary stays at `count = 3` and `stat_ovf = 1`. Repeating the test with `stat_rdy = 1` in the cycle of the second close gives summary `count = 5` and `stat_ovf = 0`.
- **Saturation.** `CNT_W = 4`; a 20-beat frame with every `exp = 200` and `thresh_exp = 0`. Required: `count = 15`, `over = 15`, `max_exp = 200`.
- **Reset mid-frame.** Assert `reset` mid-frame while 2 beats are buffered. Required: all outputs are 0 immediately, and the next `fst` after reset starts a fresh frame with no summary emitted.

Source files
------------

// File: rtl/full_err_mon_pkg.sv
// full_err_mon_pkg: shared types and constants for the full_err error monitor
package full_err_mon_pkg;
  localparam int ERR_STAT_CNT_W = 16;
  typedef struct packed {
    logic [23:0] man;
    logic [7:0]  exp;
  } float_24_8;
  typedef struct packed {
    logic [ERR_STAT_CNT_W-1:0] count;
    logic [7:0]                max_exp;
    logic [ERR_STAT_CNT_W-1:0] over;
  } err_stat_t;
endpackage

// File: rtl/full_err_mon_skid.sv
// full_err_mon_skid: 2-entry valid/ready FIFO with a registered input ready
module full_err_mon_skid #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_vld,
  output logic         in_rdy,
  output logic [W-1:0] out_data,
  output logic         out_vld,
  input  logic         out_rdy
);
  logic [W-1:0] mem [2];
  logic wr_ptr, rd_ptr, push, pop;
  logic [1:0] used, used_nxt;
  // handshakes, occupancy update and zero-gated head entry
  always_comb begin
    out_vld = used != 2'd0;
    push = in_vld && in_rdy;
    pop = out_vld && out_rdy;
    used_nxt = used + {1'b0, push} - {1'b0, pop};
    out_data = out_vld ? mem[rd_ptr] : '0;
  end
  // storage needs no reset: stale entries are never visible past the gate
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_data;
  // pointers, occupancy and ready held low through reset
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      used <= 2'd0;
      in_rdy <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop;
      used <= used_nxt;
      in_rdy <= used_nxt != 2'd2;
    end
endmodule

// File: rtl/full_err_mon.sv
// full_err_mon: forwards stage_1_error through a skid buffer and reports per-frame error statistics
module full_err_mon import full_err_mon_pkg::*; #(
  parameter int CNT_W = ERR_STAT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  float_24_8        stage_1_error,
  input  logic             stage_1_error_fst,
  input  logic             stage_1_error_vld,
  output logic             stage_1_error_rdy,
  input  logic [7:0]       thresh_exp,
  output float_24_8        stage_1_delta,
  output logic             stage_1_delta_fst,
  output logic             stage_1_delta_vld,
  input  logic             stage_1_delta_rdy,
  output logic [CNT_W-1:0] stat_count,
  output logic [7:0]       stat_max_exp,
  output logic [CNT_W-1:0] stat_over,
  output logic             stat_vld,
  input  logic             stat_rdy,
  output logic             stat_ovf
);
  typedef enum logic {IDLE, FRAME} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, over, over_nxt;
  logic [7:0] max_exp, max_nxt;
  logic [32:0] skid_out;
  logic accept, nz, hot, open, close, load;
  full_err_mon_skid #(.W(33)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .in_data  ({stage_1_error_fst, stage_1_error}),
    .in_vld   (stage_1_error_vld),
    .in_rdy   (stage_1_error_rdy),
    .out_data (skid_out),
    .out_vld  (stage_1_delta_vld),
    .out_rdy  (stage_1_delta_rdy)
  );
  assign {stage_1_delta_fst, stage_1_delta} = skid_out;
  // beat classification, frame open/close and saturating accumulator next values
  always_comb begin
    accept = stage_1_error_vld && stage_1_error_rdy;
    nz = |stage_1_error.man;
    hot = nz && (stage_1_error.exp > thresh_exp);
    open = accept && stage_1_error_fst;
    close = open && state == FRAME;
    load = close && (!stat_vld || stat_rdy);
    state_nxt = open ? FRAME : state;
    cnt_nxt = open ? CNT_W'(1) : (&cnt ? cnt : cnt + 1'b1);
    max_nxt = open ? (nz ? stage_1_error.exp : 8'd0)
                   : (nz && stage_1_error.exp > max_exp ? stage_1_error.exp : max_exp);
    over_nxt = open ? CNT_W'(hot) : (hot && !(&over) ? over + 1'b1 : over);
  end
  // frame state and accumulators; beats outside a frame are not counted
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      max_exp <= 8'd0;
      over <= '0;
    end else begin
      state <= state_nxt;
      if (open || (accept && state == FRAME)) begin
        cnt <= cnt_nxt;
        max_exp <= max_nxt;
        over <= over_nxt;
      end
    end
  // summary register: a close while a summary is still pending is dropped and flagged
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      stat_count <= '0;
      stat_max_exp <= 8'd0;
      stat_over <= '0;
      stat_vld <= 1'b0;
      stat_ovf <= 1'b0;
    end else begin
      if (load) begin
        stat_count <= cnt;
        stat_max_exp <= max_exp;
        stat_over <= over;
        stat_vld <= 1'b1;
      end else if (stat_rdy) begin
        stat_vld <= 1'b0;
      end
      if (close && !load) stat_ovf <= 1'b1;
    end
endmodule

// File: tb/tb_full_err_mon.sv
// tb_full_err_mon: directed and randomized checks of full_err_mon against a frame-level model
module tb_full_err_mon;
  import full_err_mon_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  float_24_8 err = '0;
  logic err_fst = 1'b0, err_vld = 1'b0, delta_rdy = 1'b0, stat_rdy = 1'b0;
  logic [7:0] thresh = 8'd0;
  logic rdy, delta_fst, delta_vld, stat_vld, stat_ovf;
  float_24_8 delta, s_delta;
  logic [15:0] stat_count, stat_over;
  logic [7:0] stat_max, s_max;
  logic s_rdy, s_delta_fst, s_delta_vld, s_vld, s_ovf;
  logic [3:0] s_count, s_over;
  int passed = 0, total = 0;
  logic [32:0] exp_q[$], got_q[$];
  int fb_exps[$];
  int fb_n, fb_over, m_cnt, m_max, m_over;
  bit m_in_frame, m_svld, m_ovf;

  full_err_mon #(.CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .stage_1_error(err), .stage_1_error_fst(err_fst), .stage_1_error_vld(err_vld), .stage_1_error_rdy(rdy),
    .thresh_exp(thresh),
    .stage_1_delta(delta), .stage_1_delta_fst(delta_fst), .stage_1_delta_vld(delta_vld), .stage_1_delta_rdy(delta_rdy),
    .stat_count(stat_count), .stat_max_exp(stat_max), .stat_over(stat_over),
    .stat_vld(stat_vld), .stat_rdy(stat_rdy), .stat_ovf(stat_ovf)
  );

  full_err_mon #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .stage_1_error(err), .stage_1_error_fst(err_fst), .stage_1_error_vld(err_vld), .stage_1_error_rdy(s_rdy),
    .thresh_exp(thresh),
    .stage_1_delta(s_delta), .stage_1_delta_fst(s_delta_fst), .stage_1_delta_vld(s_delta_vld), .stage_1_delta_rdy(delta_rdy),
    .stat_count(s_count), .stat_max_exp(s_max), .stat_over(s_over),
    .stat_vld(s_vld), .stat_rdy(stat_rdy), .stat_ovf(s_ovf)
  );

  always #5 clk = ~clk;

  // one clock: records handshakes, updates the frame model, returns at the next negedge
  task automatic tick(output bit acc);
    bit close;
    acc = err_vld && rdy;
    if (delta_vld && delta_rdy) got_q.push_back({delta_fst, delta});
    close = acc && err_fst && m_in_frame;
    if (close) begin
      if (!m_svld || stat_rdy) begin
        m_svld = 1;
        m_cnt = fb_n;
        m_over = fb_over;
        m_max = 0;
        foreach (fb_exps[i]) if (fb_exps[i] > m_max) m_max = fb_exps[i];
      end else m_ovf = 1;
    end else if (stat_rdy) m_svld = 0;
    if (acc) begin
      exp_q.push_back({err_fst, err});
      if (err_fst) begin
        m_in_frame = 1;
        fb_n = 0;
        fb_over = 0;
        fb_exps.delete();
      end
      if (m_in_frame) begin
        fb_n++;
        if (err.man != 0) begin
          fb_exps.push_back(int'(err.exp));
          if (err.exp > thresh) fb_over++;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bit a;
    reset = 1;
    err_vld = 0;
    err_fst = 0;
    err = '0;
    delta_rdy = 1;
    stat_rdy = 0;
    @(negedge clk);
    reset = 0;
    exp_q.delete();
    got_q.delete();
    fb_exps.delete();
    fb_n = 0;
    fb_over = 0;
    m_in_frame = 0;
    m_svld = 0;
    m_ovf = 0;
    tick(a);
  endtask

  task automatic send(bit fst, logic [23:0] man, logic [7:0] e);
    bit a;
    err_fst = fst;
    err.man = man;
    err.exp = e;
    err_vld = 1;
    a = 0;
    for (int i = 0; i < 40 && !a; i++) tick(a);
    err_vld = 0;
    total++;
    if (!a) $display("FAIL send_accept: beat not accepted within 40 cycles (got rdy=%b, want accept)", rdy);
    else passed++;
  endtask

  task automatic drain();
    bit a;
    delta_rdy = 1;
    err_vld = 0;
    repeat (4) tick(a);
  endtask

  task automatic test_reset();
    bit a;
    @(negedge clk);
    total++;
    if ({rdy, delta_vld, delta, delta_fst, stat_vld, stat_count, stat_max, stat_over, stat_ovf} !== '0)
      $display("FAIL reset_outputs: got rdy=%b dvld=%b d=%h fst=%b svld=%b cnt=%0d max=%0d over=%0d ovf=%b, want all 0",
               rdy, delta_vld, delta, delta_fst, stat_vld, stat_count, stat_max, stat_over, stat_ovf);
    else passed++;
    reset = 0;
    tick(a);
    total++;
    if (rdy !== 1'b1) $display("FAIL reset_release_rdy: got %b want 1", rdy);
    else passed++;
  endtask

  task automatic test_basic();
    do_reset();
    thresh = 100;
    send(1, 24'h1, 90);
    send(0, 24'h5, 120);
    send(0, 24'h7, 101);
    send(0, 24'h0, 0);
    total++;
    if (stat_vld !== 1'b0) $display("FAIL basic_no_early_summary: got stat_vld=%b want 0", stat_vld);
    else passed++;
    send(1, 24'h3, 50);
    total++;
    if ({stat_vld, stat_count, stat_max, stat_over} !== {1'b1, 16'd4, 8'd120, 16'd2})
      $display("FAIL basic_summary: got vld=%b cnt=%0d max=%0d over=%0d want 1/4/120/2", stat_vld, stat_count, stat_max, stat_over);
    else passed++;
    drain();
    total++;
    if (got_q.size() !== 5) $display("FAIL basic_stream_len: got %0d want 5", got_q.size());
    else passed++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) $display("FAIL basic_stream[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
    stat_rdy = 1;
    drain();
    stat_rdy = 0;
    total++;
    if (stat_vld !== 1'b0) $display("FAIL basic_summary_pop: got stat_vld=%b want 0", stat_vld);
    else passed++;
  endtask

  task automatic test_leading();
    do_reset();
    thresh = 100;
    send(0, 24'h1, 10);
    send(0, 24'h1, 11);
    send(0, 24'h1, 12);
    send(1, 24'h1, 20);
    send(0, 24'h1, 30);
    send(1, 24'h1, 40);
    total++;
    if ({stat_vld, stat_count, stat_max, stat_over} !== {1'b1, 16'd2, 8'd30, 16'd0})
      $display("FAIL leading_summary: got vld=%b cnt=%0d max=%0d over=%0d want 1/2/30/0", stat_vld, stat_count, stat_max, stat_over);
    else passed++;
    drain();
    total++;
    if (got_q.size() !== 6) $display("FAIL leading_stream_len: got %0d want 6", got_q.size());
    else passed++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) $display("FAIL leading_stream[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_backpressure();
    bit a;
    int idx;
    do_reset();
    delta_rdy = 0;
    idx = 0;
    repeat (6) begin
      err_vld = 1;
      err_fst = idx == 0;
      err.man = 24'(idx + 1);
      err.exp = 8'(idx * 7);
      tick(a);
      if (a) idx++;
    end
    err_vld = 0;
    total++;
    if (idx !== 2) $display("FAIL bp_accepted: got %0d want 2", idx);
    else passed++;
    total++;
    if ({rdy, delta_vld} !== 2'b01) $display("FAIL bp_rdy_low: got rdy=%b dvld=%b want 0/1", rdy, delta_vld);
    else passed++;
    delta_rdy = 1;
    for (int i = idx; i < 10; i++) send(i == 0, 24'(i + 1), 8'(i * 7));
    drain();
    total++;
    if (got_q.size() !== 10) $display("FAIL bp_stream_len: got %0d want 10", got_q.size());
    else passed++;
    for (int i = 0; i < 10 && i < got_q.size(); i++) begin
      total++;
      if (got_q[i][32:8] !== {i == 0, 24'(i + 1)}) $display("FAIL bp_stream[%0d]: got %h want man %0d", i, got_q[i], i + 1);
      else passed++;
    end
  endtask

  task automatic test_overflow();
    do_reset();
    stat_rdy = 0;
    send(1, 24'h1, 1);
    repeat (2) send(0, 24'h1, 1);
    send(1, 24'h1, 1);
    repeat (4) send(0, 24'h1, 1);
    send(1, 24'h1, 1);
    total++;
    if ({stat_vld, stat_count, stat_ovf} !== {1'b1, 16'd3, 1'b1})
      $display("FAIL ovf_drop: got vld=%b cnt=%0d ovf=%b want 1/3/1", stat_vld, stat_count, stat_ovf);
    else passed++;
    do_reset();
    send(1, 24'h1, 1);
    repeat (2) send(0, 24'h1, 1);
    send(1, 24'h1, 1);
    repeat (4) send(0, 24'h1, 1);
    stat_rdy = 1;
    send(1, 24'h1, 1);
    stat_rdy = 0;
    total++;
    if ({stat_vld, stat_count, stat_ovf} !== {1'b1, 16'd5, 1'b0})
      $display("FAIL ovf_pop_same_cycle: got vld=%b cnt=%0d ovf=%b want 1/5/0", stat_vld, stat_count, stat_ovf);
    else passed++;
  endtask

  task automatic test_saturation();
    do_reset();
    thresh = 0;
    send(1, 24'h1, 200);
    repeat (19) send(0, 24'h1, 200);
    send(1, 24'h1, 200);
    total++;
    if ({s_vld, s_count, s_over, s_max} !== {1'b1, 4'd15, 4'd15, 8'd200})
      $display("FAIL sat_w4: got vld=%b cnt=%0d over=%0d max=%0d want 1/15/15/200", s_vld, s_count, s_over, s_max);
    else passed++;
    total++;
    if ({stat_count, stat_over} !== {16'd20, 16'd20})
      $display("FAIL sat_w16: got cnt=%0d over=%0d want 20/20", stat_count, stat_over);
    else passed++;
  endtask

  task automatic test_reset_mid();
    bit a;
    do_reset();
    stat_rdy = 0;
    thresh = 5;
    send(1, 24'h1, 9);
    send(0, 24'h1, 9);
    send(1, 24'h1, 9);
    tick(a);
    delta_rdy = 0;
    send(0, 24'h1, 9);
    send(0, 24'h1, 9);
    total++;
    if ({rdy, delta_vld, stat_vld} !== 3'b011) $display("FAIL mid_setup: got rdy=%b dvld=%b svld=%b want 0/1/1", rdy, delta_vld, stat_vld);
    else passed++;
    #2 reset = 1;
    #1;
    total++;
    if ({rdy, delta_vld, delta, delta_fst, stat_vld, stat_count, stat_max, stat_over, stat_ovf,
         s_rdy, s_delta_vld, s_delta, s_delta_fst, s_vld, s_count, s_max, s_over, s_ovf} !== '0)
      $display("FAIL mid_reset_outputs: got rdy=%b dvld=%b d=%h svld=%b cnt=%0d s_dvld=%b s_vld=%b want all 0",
               rdy, delta_vld, delta, stat_vld, stat_count, s_delta_vld, s_vld);
    else passed++;
    do_reset();
    send(1, 24'h1, 3);
    send(0, 24'h1, 7);
    tick(a);
    total++;
    if (stat_vld !== 1'b0) $display("FAIL mid_fresh_no_summary: got stat_vld=%b want 0", stat_vld);
    else passed++;
    send(1, 24'h1, 1);
    total++;
    if ({stat_vld, stat_count, stat_max, stat_over} !== {1'b1, 16'd2, 8'd7, 16'd1})
      $display("FAIL mid_fresh_summary: got vld=%b cnt=%0d max=%0d over=%0d want 1/2/7/1", stat_vld, stat_count, stat_max, stat_over);
    else passed++;
  endtask

  task automatic test_random();
    bit a;
    do_reset();
    thresh = 8'($urandom);
    for (int n = 0; n < 600; n++) begin
      err_vld = $urandom_range(0, 3) != 0;
      err_fst = $urandom_range(0, 5) == 0;
      err.man = $urandom_range(0, 3) == 0 ? 24'd0 : 24'($urandom);
      err.exp = 8'($urandom);
      if ($urandom_range(0, 49) == 0) thresh = 8'($urandom);
      delta_rdy = $urandom_range(0, 3) != 0;
      stat_rdy = $urandom_range(0, 2) == 0;
      tick(a);
      total++;
      if ({stat_vld, stat_ovf, s_vld, s_ovf} !== {m_svld, m_ovf, m_svld, m_ovf})
        $display("FAIL rand_flags@%0d: got vld=%b ovf=%b s_vld=%b s_ovf=%b want vld=%b ovf=%b", n, stat_vld, stat_ovf, s_vld, s_ovf, m_svld, m_ovf);
      else passed++;
      if (m_svld) begin
        total++;
        if ({stat_count, stat_max, stat_over} !== {16'(m_cnt > 65535 ? 65535 : m_cnt), 8'(m_max), 16'(m_over > 65535 ? 65535 : m_over)})
          $display("FAIL rand_summary@%0d: got cnt=%0d max=%0d over=%0d want %0d/%0d/%0d", n, stat_count, stat_max, stat_over, m_cnt, m_max, m_over);
        else passed++;
        total++;
        if ({s_count, s_max, s_over} !== {4'(m_cnt > 15 ? 15 : m_cnt), 8'(m_max), 4'(m_over > 15 ? 15 : m_over)})
          $display("FAIL rand_summary_w4@%0d: got cnt=%0d max=%0d over=%0d want sat of %0d/%0d/%0d", n, s_count, s_max, s_over, m_cnt, m_max, m_over);
        else passed++;
      end
    end
    drain();
    total++;
    if (got_q.size() !== exp_q.size()) $display("FAIL rand_stream_len: got %0d want %0d", got_q.size(), exp_q.size());
    else passed++;
    foreach (exp_q[i]) if (i < got_q.size()) begin
      total++;
      if (got_q[i] !== exp_q[i]) $display("FAIL rand_stream[%0d]: got %h want %h", i, got_q[i], exp_q[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_leading();
    test_backpressure();
    test_overflow();
    test_saturation();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
